sump_cmd_decoder: RTL and testbench

FPGA-side responder for the SUMP host command protocol: consumes bytes from the UART receiver and assembles them into short (1-byte) and long (opcode + 32-bit little-endian argument) commands. Sits between the UART receiver and the analyzer's configuration registers and controller. Presents each completed command as a single-cycle strobe with opcode and argument. Also pulses decoded strobes for the control opcodes. An inter-byte timeout resynchronises on a stalled long command.

---
 rtl/sump_pkg.sv | 30 +++
 rtl/sump_cmd_decoder.sv | 173 +++++++++++++++++
 tb/tb_sump_cmd_decoder.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/sump_pkg.sv
// Purpose: shared SUMP protocol constants and decoder state type.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sump_pkg;

    // Bit of an opcode byte that marks a long (opcode + 32-bit argument) command.
    localparam int LONG_BIT = 7;

    // Short commands
    localparam logic [7:0] OP_RESET      = 8'h00;
    localparam logic [7:0] OP_RUN        = 8'h01;
    localparam logic [7:0] OP_ID         = 8'h02;
    localparam logic [7:0] OP_META       = 8'h04;
    localparam logic [7:0] OP_XON        = 8'h11;
    localparam logic [7:0] OP_XOFF       = 8'h13;

    // Long commands
    localparam logic [7:0] OP_DIV        = 8'h80;
    localparam logic [7:0] OP_CNT        = 8'h81;
    localparam logic [7:0] OP_FLAGS      = 8'h82;
    localparam logic [7:0] OP_TRIG_MASK0 = 8'hC0;
    localparam logic [7:0] OP_TRIG_VAL0  = 8'hC1;
    localparam logic [7:0] OP_TRIG_CFG0  = 8'hC2;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_ARG  = 1'b1
    } dec_state_t;

endpackage : sump_pkg

// File: rtl/sump_cmd_decoder.sv
// Purpose: assembles UART bytes into SUMP short/long commands, pulses decoded control strobes.
// Latency: 1 cycle from the final byte's rx_valid to cmd_valid and strobes; all outputs registered.
// Backpressure: none; every rx_valid byte is accepted, one byte per cycle sustained.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   rx_data, rx_valid   byte stream from the UART receiver
//   cmd_valid/cmd_long  one-cycle completion pulse and long-command qualifier
//   cmd_op, cmd_data    last opcode / last long argument, held between commands
//   cmd_reset..cmd_xoff decoded one-cycle pulses for the control opcodes
//   cmd_abort           partial long command dropped on inter-byte timeout
//   busy                long command partially received
module sump_cmd_decoder
    import sump_pkg::*;
#(
    parameter int TIMEOUT_CYC = 100_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        cmd_valid,
    output logic        cmd_long,
    output logic [7:0]  cmd_op,
    output logic [31:0] cmd_data,
    output logic        cmd_reset,
    output logic        cmd_run,
    output logic        cmd_id,
    output logic        cmd_meta,
    output logic        cmd_xon,
    output logic        cmd_xoff,
    output logic        cmd_abort,
    output logic        busy
);

    dec_state_t  state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [7:0]  op_sh_q, op_sh_d;
    logic [31:0] arg_sh_q, arg_sh_d;
    logic        timeout_hit;

    logic        valid_d, long_d, abort_d;
    logic [7:0]  op_d;
    logic [31:0] data_d;
    logic        reset_d, run_d, id_d, meta_d, xon_d, xoff_d;

    // Inter-byte timeout: only runs while a long command is in flight. The
    // terminal compare excludes rx_valid so a byte landing on the last count
    // is taken as data instead of triggering an abort.
    generate
        if (TIMEOUT_CYC > 0) begin : g_timeout
            localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
            logic [CNT_W-1:0] to_cnt_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    to_cnt_q <= '0;
                end else if (state_q != ST_ARG || rx_valid) begin
                    to_cnt_q <= '0;
                end else begin
                    to_cnt_q <= to_cnt_q + 1'b1;
                end
            end

            assign timeout_hit = (state_q == ST_ARG) && !rx_valid &&
                                 (to_cnt_q == CNT_W'(TIMEOUT_CYC - 1));
        end else begin : g_no_timeout
            assign timeout_hit = 1'b0;
        end
    endgenerate

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        op_sh_d  = op_sh_q;
        arg_sh_d = arg_sh_q;
        valid_d  = 1'b0;
        long_d   = 1'b0;
        abort_d  = 1'b0;
        op_d     = cmd_op;
        data_d   = cmd_data;
        reset_d  = 1'b0;
        run_d    = 1'b0;
        id_d     = 1'b0;
        meta_d   = 1'b0;
        xon_d    = 1'b0;
        xoff_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (rx_valid) begin
                    if (rx_data[LONG_BIT]) begin
                        op_sh_d  = rx_data;
                        arg_sh_d = '0;
                        idx_d    = 2'd0;
                        state_d  = ST_ARG;
                    end else begin
                        valid_d = 1'b1;
                        op_d    = rx_data;
                        case (rx_data)
                            OP_RESET: reset_d = 1'b1;
                            OP_RUN:   run_d   = 1'b1;
                            OP_ID:    id_d    = 1'b1;
                            OP_META:  meta_d  = 1'b1;
                            OP_XON:   xon_d   = 1'b1;
                            OP_XOFF:  xoff_d  = 1'b1;
                            default:  ;
                        endcase
                    end
                end
            end
            ST_ARG: begin
                if (rx_valid) begin
                    // Little-endian: first argument byte lands in bits [7:0].
                    arg_sh_d[{idx_q, 3'b000} +: 8] = rx_data;
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        valid_d = 1'b1;
                        long_d  = 1'b1;
                        op_d    = op_sh_q;
                        data_d  = arg_sh_d;
                        state_d = ST_IDLE;
                    end
                end else if (timeout_hit) begin
                    abort_d = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            idx_q     <= 2'd0;
            op_sh_q   <= 8'h00;
            arg_sh_q  <= 32'h0;
            cmd_valid <= 1'b0;
            cmd_long  <= 1'b0;
            cmd_op    <= 8'h00;
            cmd_data  <= 32'h0;
            cmd_reset <= 1'b0;
            cmd_run   <= 1'b0;
            cmd_id    <= 1'b0;
            cmd_meta  <= 1'b0;
            cmd_xon   <= 1'b0;
            cmd_xoff  <= 1'b0;
            cmd_abort <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            op_sh_q   <= op_sh_d;
            arg_sh_q  <= arg_sh_d;
            cmd_valid <= valid_d;
            cmd_long  <= long_d;
            cmd_op    <= op_d;
            cmd_data  <= data_d;
            cmd_reset <= reset_d;
            cmd_run   <= run_d;
            cmd_id    <= id_d;
            cmd_meta  <= meta_d;
            cmd_xon   <= xon_d;
            cmd_xoff  <= xoff_d;
            cmd_abort <= abort_d;
        end
    end

    // busy is the state register itself, so it rises the cycle after the
    // opcode byte and drops together with cmd_valid or cmd_abort.
    assign busy = (state_q == ST_ARG);

endmodule : sump_cmd_decoder

// File: tb/tb_sump_cmd_decoder.sv
// Purpose: directed self-checking bench for sump_cmd_decoder.
// Latency: checks outputs 1 ns after the edge that samples each byte.
// Backpressure: n/a; bytes are driven one per cycle.
module tb_sump_cmd_decoder;

    localparam int TO = 20;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        cmd_valid, cmd_long;
    logic [7:0]  cmd_op;
    logic [31:0] cmd_data;
    logic        cmd_reset, cmd_run, cmd_id, cmd_meta, cmd_xon, cmd_xoff;
    logic        cmd_abort, busy;

    int n_checks = 0;
    int n_fail   = 0;

    sump_cmd_decoder #(.TIMEOUT_CYC(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .cmd_valid (cmd_valid),
        .cmd_long  (cmd_long),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .cmd_reset (cmd_reset),
        .cmd_run   (cmd_run),
        .cmd_id    (cmd_id),
        .cmd_meta  (cmd_meta),
        .cmd_xon   (cmd_xon),
        .cmd_xoff  (cmd_xoff),
        .cmd_abort (cmd_abort),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] strobes();
        return {cmd_reset, cmd_run, cmd_id, cmd_meta, cmd_xon, cmd_xoff};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive one byte for exactly one edge; return 1 ns after that edge.
    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    logic [7:0] short_ops [7] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h11, 8'h13, 8'h05};
    logic [5:0] short_exp [7] = '{6'b100000, 6'b010000, 6'b001000, 6'b000100,
                                  6'b000010, 6'b000001, 6'b000000};

    initial begin
        rst      = 1'b1;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        idle_cycles(2);
        rst = 1'b0;

        // Reset state
        check("rst_valid",   32'(cmd_valid), 32'd0);
        check("rst_long",    32'(cmd_long),  32'd0);
        check("rst_op",      32'(cmd_op),    32'h00);
        check("rst_data",    cmd_data,       32'h0);
        check("rst_strobes", 32'(strobes()), 32'd0);
        check("rst_abort",   32'(cmd_abort), 32'd0);
        check("rst_busy",    32'(busy),      32'd0);

        // Five back-to-back 0x00 bytes: five reset pulses, never busy
        for (int i = 0; i < 5; i++) begin
            send_byte(8'h00);
            check("r5_valid", 32'(cmd_valid), 32'd1);
            check("r5_reset", 32'(cmd_reset), 32'd1);
            check("r5_long",  32'(cmd_long),  32'd0);
            check("r5_busy",  32'(busy),      32'd0);
        end
        idle_cycles(1);
        check("r5_valid_drop", 32'(cmd_valid), 32'd0);

        // Decoded strobes for each short opcode, plus an unknown one
        for (int i = 0; i < 7; i++) begin
            send_byte(short_ops[i]);
            check("short_valid",   32'(cmd_valid), 32'd1);
            check("short_op",      32'(cmd_op),    32'(short_ops[i]));
            check("short_strobes", 32'(strobes()), 32'(short_exp[i]));
            idle_cycles(1);
        end

        // Long command 0x81 04 00 04 00 on consecutive cycles
        send_byte(8'h81);
        check("l81_busy0",  32'(busy),      32'd1);
        check("l81_valid0", 32'(cmd_valid), 32'd0);
        send_byte(8'h04);
        check("l81_busy1",  32'(busy), 32'd1);
        send_byte(8'h00);
        check("l81_busy2",  32'(busy), 32'd1);
        send_byte(8'h04);
        check("l81_busy3",  32'(busy),      32'd1);
        check("l81_valid3", 32'(cmd_valid), 32'd0);
        send_byte(8'h00);
        check("l81_valid",  32'(cmd_valid), 32'd1);
        check("l81_long",   32'(cmd_long),  32'd1);
        check("l81_op",     32'(cmd_op),    32'h81);
        check("l81_data",   cmd_data,       32'h0004_0004);
        check("l81_busy",   32'(busy),      32'd0);
        idle_cycles(1);
        check("l81_pulse",  32'(cmd_valid), 32'd0);

        // Partial 0x82 then silence: abort exactly TO cycles after the last byte
        send_byte(8'h82);
        send_byte(8'h11);
        send_byte(8'h22);
        idle_cycles(TO - 1);
        check("to_busy_pre",  32'(busy),      32'd1);
        check("to_abort_pre", 32'(cmd_abort), 32'd0);
        idle_cycles(1);
        check("to_abort",     32'(cmd_abort), 32'd1);
        check("to_busy",      32'(busy),      32'd0);
        check("to_valid",     32'(cmd_valid), 32'd0);
        check("to_op_held",   32'(cmd_op),    32'h81);
        check("to_data_held", cmd_data,       32'h0004_0004);
        idle_cycles(1);
        check("to_abort_pulse", 32'(cmd_abort), 32'd0);
        send_byte(8'h02);
        check("to_id",        32'(cmd_id),    32'd1);
        check("to_id_valid",  32'(cmd_valid), 32'd1);
        check("to_id_data",   cmd_data,       32'h0004_0004);
        idle_cycles(1);

        // Final byte lands on the terminal timeout count: byte wins
        send_byte(8'hC0);
        send_byte(8'hFF);
        send_byte(8'h00);
        send_byte(8'h00);
        idle_cycles(TO - 1);
        check("tie_busy_pre", 32'(busy), 32'd1);
        send_byte(8'h00);
        check("tie_abort", 32'(cmd_abort), 32'd0);
        check("tie_valid", 32'(cmd_valid), 32'd1);
        check("tie_long",  32'(cmd_long),  32'd1);
        check("tie_op",    32'(cmd_op),    32'hC0);
        check("tie_data",  cmd_data,       32'h0000_00FF);
        idle_cycles(1);
        check("tie_abort_after", 32'(cmd_abort), 32'd0);

        // Reset mid-command discards the partial long command
        send_byte(8'h80);
        send_byte(8'h55);
        rst = 1'b1;
        idle_cycles(1);
        rst = 1'b0;
        check("mrst_busy", 32'(busy),     32'd0);
        check("mrst_data", cmd_data,      32'h0);
        check("mrst_op",   32'(cmd_op),   32'h00);
        send_byte(8'h01);
        check("mrst_run",   32'(cmd_run),   32'd1);
        check("mrst_valid", 32'(cmd_valid), 32'd1);
        check("mrst_long",  32'(cmd_long),  32'd0);
        check("mrst_data2", cmd_data,       32'h0);
        idle_cycles(3);
        check("mrst_no_long", 32'(cmd_valid), 32'd0);
        check("mrst_idle",    32'(busy),      32'd0);

        // Zero argument bytes are data; the fifth 0x00 is a reset
        send_byte(8'h82);
        for (int i = 0; i < 3; i++) begin
            send_byte(8'h00);
            check("z_no_reset", 32'(cmd_reset), 32'd0);
        end
        send_byte(8'h00);
        check("z_valid", 32'(cmd_valid), 32'd1);
        check("z_long",  32'(cmd_long),  32'd1);
        check("z_op",    32'(cmd_op),    32'h82);
        check("z_data",  cmd_data,       32'h0);
        check("z_reset_arg", 32'(cmd_reset), 32'd0);
        send_byte(8'h00);
        check("z_reset", 32'(cmd_reset), 32'd1);
        check("z_short", 32'(cmd_long),  32'd0);
        idle_cycles(1);
        check("z_reset_once", 32'(cmd_reset), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_sump_cmd_decoder
